// File: rtl/wallace_cpa_pipe_pkg.sv
// Shared constants for the Booth/Wallace 16x16 multiplier datapath.
// The Booth generator, compressor tree and final adder all size from these.
package wallace_cpa_pipe_pkg;

    localparam int MULT_W    = 16;
    localparam int PROD_W    = 2 * MULT_W;
    localparam int CPA_WIDTH = PROD_W;
    localparam int CPA_SPLIT = MULT_W;

endpackage

// File: rtl/wallace_cpa_pipe_cpa.sv
// N-bit ripple/inferred adder segment with carry-in and carry-out.
// Used once per pipeline half of the final carry-propagate adder.
module cpa_segment #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/wallace_cpa_pipe.sv
// Final carry-propagate adder of the 16x16 multiplier: adds the sum and carry
// rows in two pipeline stages (low half, then high half with the mid carry).
module wallace_cpa_pipe
    import wallace_cpa_pipe_pkg::*;
#(
    parameter int WIDTH = CPA_WIDTH,
    parameter int SPLIT = CPA_SPLIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum_i,
    input  logic [WIDTH-1:0] carry_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] product_o
);

    localparam int HI_W = WIDTH - SPLIT;

    // Handshake: a beat moves across an interface in any cycle where both
    // valid and ready are high; valid never waits on ready, and in_ready is
    // a function of pipeline state and out_ready only (never of in_valid).

    logic              s1_valid;
    logic              s2_valid;
    logic [SPLIT-1:0]  lo_sum;
    logic              c_mid;
    logic [HI_W-1:0]   hi_a;
    logic [HI_W-1:0]   hi_b;

    logic [SPLIT-1:0]  lo_sum_d;
    logic              lo_cout;
    logic [HI_W-1:0]   hi_sum_d;
    logic              hi_cout_unused;

    logic              s2_free;
    logic              s1_adv;
    logic              accept;

    assign s2_free   = !s2_valid || out_ready;
    assign s1_adv    = s1_valid && s2_free;
    assign in_ready  = !s1_valid || s2_free;
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_valid;

    cpa_segment #(.N(SPLIT)) u_lo (
        .a    (sum_i[SPLIT-1:0]),
        .b    (carry_i[SPLIT-1:0]),
        .cin  (1'b0),
        .sum  (lo_sum_d),
        .cout (lo_cout)
    );

    // Carry out of the top bit is the mod-2^WIDTH wrap and is dropped.
    cpa_segment #(.N(HI_W)) u_hi (
        .a    (hi_a),
        .b    (hi_b),
        .cin  (c_mid),
        .sum  (hi_sum_d),
        .cout (hi_cout_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            lo_sum   <= '0;
            c_mid    <= 1'b0;
            hi_a     <= '0;
            hi_b     <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                lo_sum   <= lo_sum_d;
                c_mid    <= lo_cout;
                hi_a     <= sum_i[WIDTH-1:SPLIT];
                hi_b     <= carry_i[WIDTH-1:SPLIT];
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            product_o <= '0;
        end else begin
            if (s1_adv) begin
                s2_valid  <= 1'b1;
                product_o <= {hi_sum_d, lo_sum};
            end else if (out_ready) begin
                s2_valid  <= 1'b0;
            end
        end
    end

endmodule
